// File: rtl/fetch_unit_pkg.sv
// Shared rv32 constants for the instruction fetch path: register width, PC step
// and the default reset vector.
package fetch_unit_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int              FIFO_DEPTH       = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry first-word-fall-through buffer between instruction memory and decode.
// Supports simultaneous push/pop and a synchronous clear that wins over both.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic             empty, full, push_ok, pop_ok;

  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'(FIFO_DEPTH));

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = wdata;
    if (clr) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the output is forced to zero while empty instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, one-cycle memory latency tracking,
// a two-entry decode buffer with valid/ready handshake, and redirect flushing.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    WIDTH_ADDR = XLEN,
  parameter int                    WIDTH_DATA = XLEN,
  parameter logic [WIDTH_ADDR-1:0] RESET_PC   = WIDTH_ADDR'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [WIDTH_ADDR-1:0] redirect_pc,
  output logic [WIDTH_ADDR-1:0] imem_addr,
  input  logic [WIDTH_DATA-1:0] imem_instr,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [WIDTH_ADDR-1:0] if_pc,
  output logic [WIDTH_DATA-1:0] if_instr
);

  localparam int ENTRY_W = WIDTH_ADDR + WIDTH_DATA;

  logic [WIDTH_ADDR-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [WIDTH_ADDR-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]            fifo_count;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [2:0]            occupancy;
  logic                  pop, issue;
  logic [1:0]            unused_redirect_ofs;

  assign unused_redirect_ofs = redirect_pc[1:0];

  assign pop       = if_valid & if_ready;
  // Slots already committed (buffered + in flight) after this cycle's pop; keeps the FIFO from overflowing.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (occupancy < 3'd2) & ~redirect_valid;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[WIDTH_ADDR-1:2], 2'b00};
    end else if (issue) begin
      pc_d          = pc_q + WIDTH_ADDR'(PC_INC);
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // A redirect squashes the returning word and discards any accepted head this cycle.
  fetch_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (redirect_valid),
    .push  (inflight_q & ~redirect_valid),
    .pop   (pop & ~redirect_valid),
    .wdata ({inflight_pc_q, imem_instr}),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  assign imem_addr          = {2'b00, pc_q[WIDTH_ADDR-1:2]};
  assign if_valid           = (fifo_count != 2'd0);
  assign {if_pc, if_instr}  = fifo_head;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-based model of the expected PC stream
// is checked by a negedge monitor while directed and random stimulus runs.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        mon_t;
  logic [31:0] gen_pc;
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_out  = '0;

  fetch_unit #(
    .WIDTH_ADDR (32),
    .WIDTH_DATA (32),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory: word k holds 0x1000_0000 + k.
  always @(posedge clk) imem_instr <= 32'h1000_0000 + imem_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Reference stream: after a restart, instructions appear at target, target+4, ... in order.
  function automatic void top_up();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: gen_pc, instr: 32'h1000_0000 + (gen_pc / 4)});
      gen_pc = gen_pc + 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] target);
    exp_q.delete();
    gen_pc = target & 32'hFFFF_FFFC;
    top_up();
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", {63'd0, if_valid}, 64'd1);
        check("hold_data", {if_pc, if_instr}, prev_out);
      end
      if (!if_valid) begin
        check("idle_zero", {if_pc, if_instr}, 64'd0);
      end else if (if_ready && !redirect_valid) begin
        top_up();
        mon_t = exp_q.pop_front();
        check("out_pc", {32'd0, if_pc}, {32'd0, mon_t.pc});
        check("out_instr", {32'd0, if_instr}, {32'd0, mon_t.instr});
      end
      prev_hold = if_valid && !if_ready && !redirect_valid;
      prev_out  = {if_pc, if_instr};
    end
  end

  task automatic stream(input int n, input bit check_rate);
    int v = 0;
    @(posedge clk); #1;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (if_valid) v++;
    end
    if (check_rate) check("throughput", 64'(v), 64'(n));
  endtask

  task automatic mid_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", {63'd0, if_valid}, 64'd0);
    check("rst_async_out", {if_pc, if_instr}, 64'd0);
    check("rst_imem_addr", {32'd0, imem_addr}, {32'd0, RST_PC / 4});
    redirect_valid = 1'b0;
    restart(RST_PC);
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_lat_valid", {63'd0, if_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("rel_first_valid", {63'd0, if_valid}, 64'd1);
    check("rel_first_pc", {32'd0, if_pc}, {32'd0, RST_PC});
  endtask

  task automatic drive_redirect(input logic [31:0] t);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = t;
    restart(t);
  endtask

  task automatic finish_redirect(input logic [31:0] t);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_n1_valid", {63'd0, if_valid}, 64'd0);
    check("redir_imem_addr", {32'd0, imem_addr}, {32'd0, t / 4});
    @(posedge clk);
    @(negedge clk);
    check("redir_n2_valid", {63'd0, if_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("redir_n3_valid", {63'd0, if_valid}, 64'd1);
    check("redir_n3_pc", {32'd0, if_pc}, {32'd0, t & 32'hFFFF_FFFC});
  endtask

  initial begin
    rst_n          = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    restart(RST_PC);
    #12;
    check("reset_valid", {63'd0, if_valid}, 64'd0);
    check("reset_pc", {32'd0, if_pc}, 64'd0);
    check("reset_instr", {32'd0, if_instr}, 64'd0);
    check("reset_imem_addr", {32'd0, imem_addr}, {32'd0, RST_PC / 4});

    release_reset();
    stream(20, 1'b1);

    // Stall right after the first instruction appears.
    if_ready = 1'b0;
    mid_reset();
    release_reset();
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_pc", {32'd0, if_pc}, {32'd0, RST_PC});
      check("stall_pc_ahead", {63'd0, ((imem_addr * 4) - if_pc) <= 32'd8}, 64'd1);
    end
    stream(12, 1'b1);

    drive_redirect(32'h0000_0100);
    finish_redirect(32'h0000_0100);
    stream(10, 1'b1);

    // Fill the buffer, then redirect while decode is stalled.
    @(posedge clk); #1;
    if_ready = 1'b0;
    repeat (4) @(posedge clk);
    drive_redirect(32'h0000_0300);
    finish_redirect(32'h0000_0300);
    stream(8, 1'b0);

    drive_redirect(32'h0000_0206);
    finish_redirect(32'h0000_0206);
    stream(6, 1'b1);

    drive_redirect(32'h0000_0400);
    drive_redirect(32'h0000_0500);
    finish_redirect(32'h0000_0500);
    stream(6, 1'b1);

    drive_redirect(32'hFFFF_FFF8);
    finish_redirect(32'hFFFF_FFF8);
    stream(8, 1'b1);

    mid_reset();
    release_reset();
    stream(6, 1'b1);

    @(posedge clk); #1;
    if_ready = 1'b0;
    repeat (4) @(posedge clk);
    mid_reset();
    if_ready = 1'b1;
    release_reset();
    stream(6, 1'b1);

    drive_redirect(32'h0000_0700);
    mid_reset();
    release_reset();
    stream(6, 1'b1);

    repeat (400) begin
      @(posedge clk); #1;
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                                     : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        restart(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
    end
    stream(10, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
